// File: rtl/clock_set_pkg.sv
// Shared types and BCD helpers for the HH.MM time-set editor.
package clock_set_pkg;

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      SET_HR  = 2'd1,
      SET_MIN = 2'd2
   } set_state_t;

   localparam logic [7:0] HOURS_MAX   = 8'h23;
   localparam logic [7:0] MINUTES_MAX = 8'h59;

   // Anything that is not valid BCD, or is already at/above the limit, wraps to 00.
   function automatic logic [7:0] bcd_inc(input logic [7:0] value, input logic [7:0] max_value);
      logic [3:0] tens;
      logic [3:0] units;
      tens  = value[7:4];
      units = value[3:0];
      if ((tens > 4'd9) || (units > 4'd9) || (value >= max_value)) begin
         return 8'h00;
      end
      if (units == 4'd9) begin
         return {tens + 4'd1, 4'd0};
      end
      return {tens, units + 4'd1};
   endfunction

endpackage

// File: rtl/key_debounce.sv
// Synchronises one active-low push button and debounces it into an active-high level plus press pulse.
module key_debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic key_n_i,
   output logic level_o,
   output logic press_o
);

   localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic [1:0]    sync_q, sync_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          level_q, level_d;
   logic          press_q, press_d;
   logic          key_active;

   assign key_active = ~sync_q[1];

   // The counter only runs while the synchronised level disagrees with the accepted level.
   always_comb begin
      sync_d  = {sync_q[0], key_n_i};
      cnt_d   = '0;
      level_d = level_q;
      if (key_active != level_q) begin
         if (cnt_q == CNT_LAST) begin
            level_d = key_active;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
      press_d = level_d & ~level_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q  <= 2'b11;
         cnt_q   <= '0;
         level_q <= 1'b0;
         press_q <= 1'b0;
      end else begin
         sync_q  <= sync_d;
         cnt_q   <= cnt_d;
         level_q <= level_d;
         press_q <= press_d;
      end
   end

   assign level_o = level_q;
   assign press_o = press_q;

endmodule

// File: rtl/hex_clock_setter.sv
// Time-set editor: mode key cycles RUN/SET_HR/SET_MIN, increment key bumps the edited BCD field.
module hex_clock_setter #(
   parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
   parameter int unsigned REPEAT_CYCLES   = 10_000_000,
   parameter int unsigned BLINK_CYCLES    = 12_500_000
) (
   input  logic       rst_ni,
   input  logic       CLK_50,
   input  logic [1:0] KEY,
   input  logic [7:0] hours_i,
   input  logic [7:0] minutes_i,
   output logic       set_mode_o,
   output logic       load_o,
   output logic [7:0] hours_o,
   output logic [7:0] minutes_o,
   output logic [5:0] blank_o
);

   import clock_set_pkg::*;

   localparam int unsigned RW = $clog2(REPEAT_CYCLES + 1);
   localparam int unsigned BW = $clog2(BLINK_CYCLES + 1);
   localparam logic [RW-1:0] REP_LAST   = RW'(REPEAT_CYCLES - 1);
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYCLES - 1);

   logic mode_level, mode_press, inc_level, inc_press;

   key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode_key (
      .clk     (CLK_50),
      .rst_n   (rst_ni),
      .key_n_i (KEY[0]),
      .level_o (mode_level),
      .press_o (mode_press)
   );

   key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_inc_key (
      .clk     (CLK_50),
      .rst_n   (rst_ni),
      .key_n_i (KEY[1]),
      .level_o (inc_level),
      .press_o (inc_press)
   );

   set_state_t    state_q, state_d;
   logic [7:0]    hours_q, hours_d;
   logic [7:0]    minutes_q, minutes_d;
   logic          load_q, load_d;
   logic          set_mode_q, set_mode_d;
   logic [5:0]    blank_q, blank_d;
   logic [RW-1:0] rep_cnt_q, rep_cnt_d;
   logic [BW-1:0] blink_cnt_q, blink_cnt_d;
   logic          phase_q, phase_d;
   logic          mode_evt, in_set, rep_fire, inc_evt;

   // The press pulse always coincides with the level going high.
   assign mode_evt = mode_press & mode_level;
   assign in_set   = (state_q != RUN);
   assign rep_fire = in_set && inc_level && (rep_cnt_q == REP_LAST);
   assign inc_evt  = inc_press | rep_fire;

   always_comb begin
      state_d     = state_q;
      hours_d     = hours_q;
      minutes_d   = minutes_q;
      load_d      = 1'b0;
      blink_cnt_d = '0;
      phase_d     = 1'b0;

      // A mode event takes priority; an increment in the same cycle is dropped.
      unique case (state_q)
         SET_HR: begin
            if (mode_evt) begin
               state_d = SET_MIN;
            end else if (inc_evt) begin
               hours_d = bcd_inc(hours_q, HOURS_MAX);
            end
         end
         SET_MIN: begin
            if (mode_evt) begin
               state_d = RUN;
               load_d  = 1'b1;
            end else if (inc_evt) begin
               minutes_d = bcd_inc(minutes_q, MINUTES_MAX);
            end
         end
         default: begin
            if (mode_evt) begin
               state_d   = SET_HR;
               hours_d   = hours_i;
               minutes_d = minutes_i;
            end
         end
      endcase

      if (in_set && !mode_evt) begin
         if (blink_cnt_q == BLINK_LAST) begin
            phase_d = ~phase_q;
         end else begin
            blink_cnt_d = blink_cnt_q + 1'b1;
            phase_d     = phase_q;
         end
      end

      // Counting restarts at every press so repeats land a whole period after it.
      if (!in_set || !inc_level || mode_evt || inc_press || rep_fire) begin
         rep_cnt_d = '0;
      end else begin
         rep_cnt_d = rep_cnt_q + 1'b1;
      end

      set_mode_d = (state_d != RUN);
      unique case (state_d)
         SET_HR:  blank_d = {phase_d, phase_d, 4'b0000};
         SET_MIN: blank_d = {2'b00, phase_d, phase_d, 2'b00};
         default: blank_d = 6'b000000;
      endcase
   end

   always_ff @(posedge CLK_50 or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= RUN;
         hours_q     <= 8'h00;
         minutes_q   <= 8'h00;
         load_q      <= 1'b0;
         set_mode_q  <= 1'b0;
         blank_q     <= 6'b000000;
         rep_cnt_q   <= '0;
         blink_cnt_q <= '0;
         phase_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         hours_q     <= hours_d;
         minutes_q   <= minutes_d;
         load_q      <= load_d;
         set_mode_q  <= set_mode_d;
         blank_q     <= blank_d;
         rep_cnt_q   <= rep_cnt_d;
         blink_cnt_q <= blink_cnt_d;
         phase_q     <= phase_d;
      end
   end

   assign set_mode_o = set_mode_q;
   assign load_o     = load_q;
   assign hours_o    = hours_q;
   assign minutes_o  = minutes_q;
   assign blank_o    = blank_q;

endmodule
